// File: rtl/ddr_cmd_arbiter_pkg.sv
// Shared definitions for the MCB command arbiter: MCB instruction codes,
// arbiter FSM states and the burst/address field widths.
package ddr_defs;

  localparam int BL_W   = 6;
  localparam int ADDR_W = 30;

  localparam logic [2:0] MCB_CMD_RD = 3'b001;
  localparam logic [2:0] MCB_CMD_WR = 3'b000;

  typedef enum logic [1:0] {
    CALIB = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ddr_cmd_arbiter_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Shares one MCB user-port command channel between the display read fetcher
// and the fractal pixel writer, gated on calibration and write-FIFO fill.
module ddr_cmd_arbiter
  import ddr_defs::*;
#(
  parameter int ARB_MODE = 0,
  parameter int HOLD_CYC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_calib_done,
  input  logic                cmd_full,
  input  logic [6:0]          wr_count,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [BL_W-1:0]     rd_bl,
  output logic                rd_ack,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [BL_W-1:0]     wr_bl,
  output logic                wr_ack,
  output logic [2:0]          cmd_instr,
  output logic [BL_W-1:0]     cmd_bl,
  output logic [ADDR_W-1:0]   cmd_byte_addr,
  output logic                cmd_en,
  output logic                ready,
  output logic                last_grant
);

  localparam logic [1:0]        HOLD_LAST = 2'(HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = 30'h3FFF_FFFC;

  arb_state_t  state;
  logic [1:0]  hold_cnt;
  logic        cal_s;
  logic        rd_el;
  logic        wr_el;
  logic [6:0]  wr_need;
  logic        pick_wr;

  sync2 u_cal_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_calib_done),
    .q     (cal_s)
  );

  // A write burst needs all of its data words already sitting in the MCB
  // write FIFO; the 7-bit compare lets a 64-word burst need a count of 64.
  assign wr_need = {1'b0, wr_bl} + 7'd1;
  assign rd_el   = rd_req & ~cmd_full;
  assign wr_el   = wr_req & ~cmd_full & (wr_count >= wr_need);
  assign ready   = cal_s & (state == IDLE);

  always_comb begin
    pick_wr = 1'b0;
    if (wr_el && !rd_el)
      pick_wr = 1'b1;
    else if (wr_el && rd_el)
      pick_wr = (ARB_MODE == 0) ? ~last_grant : 1'b0;
  end

  // Command fields and strobes are loaded on leaving IDLE so that they are
  // presented, already stable, for the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= CALIB;
      hold_cnt      <= 2'd0;
      cmd_en        <= 1'b0;
      rd_ack        <= 1'b0;
      wr_ack        <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      last_grant    <= 1'b1;
    end else begin
      cmd_en <= 1'b0;
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      if (!cal_s) begin
        state <= CALIB;
      end else begin
        case (state)
          CALIB: state <= IDLE;
          IDLE: begin
            if (rd_el || wr_el) begin
              state         <= ISSUE;
              cmd_en        <= 1'b1;
              rd_ack        <= ~pick_wr;
              wr_ack        <= pick_wr;
              cmd_instr     <= pick_wr ? MCB_CMD_WR : MCB_CMD_RD;
              cmd_bl        <= pick_wr ? wr_bl : rd_bl;
              cmd_byte_addr <= (pick_wr ? wr_addr : rd_addr) & WORD_MASK;
              last_grant    <= pick_wr;
            end
          end
          ISSUE: begin
            state    <= HOLD;
            hold_cnt <= 2'd0;
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST)
              state <= IDLE;
            else
              hold_cnt <= hold_cnt + 2'd1;
          end
          default: state <= CALIB;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed self-checking bench for ddr_cmd_arbiter (ARB_MODE 0, HOLD_CYC 1).
module tb_ddr_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_calib_done;
  logic        cmd_full;
  logic [6:0]  wr_count;
  logic        rd_req;
  logic [29:0] rd_addr;
  logic [5:0]  rd_bl;
  logic        rd_ack;
  logic        wr_req;
  logic [29:0] wr_addr;
  logic [5:0]  wr_bl;
  logic        wr_ack;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_en;
  logic        ready;
  logic        last_grant;

  int checks = 0;
  int errors = 0;

  ddr_cmd_arbiter #(.ARB_MODE(0), .HOLD_CYC(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_calib_done (mem_calib_done),
    .cmd_full       (cmd_full),
    .wr_count       (wr_count),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_bl          (rd_bl),
    .rd_ack         (rd_ack),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_bl          (wr_bl),
    .wr_ack         (wr_ack),
    .cmd_instr      (cmd_instr),
    .cmd_bl         (cmd_bl),
    .cmd_byte_addr  (cmd_byte_addr),
    .cmd_en         (cmd_en),
    .ready          (ready),
    .last_grant     (last_grant)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rq_r, input logic [29:0] ra, input logic [5:0] rb,
                               input logic rq_w, input logic [29:0] wa, input logic [5:0] wb);
    rd_req  = rq_r;
    rd_addr = ra;
    rd_bl   = rb;
    wr_req  = rq_w;
    wr_addr = wa;
    wr_bl   = wb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until cmd_en is seen, or -1 if it never is.
  task automatic waitCmd(input int maxCyc, output int n);
    n = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      tick();
      if (cmd_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countCycles(input int cyc, output int ens, output int acks, output int rdys);
    ens = 0;
    acks = 0;
    rdys = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      ens  += int'(cmd_en);
      acks += int'(rd_ack) + int'(wr_ack);
      rdys += int'(ready);
    end
  endtask

  initial begin
    int n, ens, acks, rdys;
    logic [2:0] expInstr;

    reset          = 1'b0;
    mem_calib_done = 1'b0;
    cmd_full       = 1'b0;
    wr_count       = 7'd0;
    applyStimulus(1'b0, 30'd0, 6'd0, 1'b0, 30'd0, 6'd0);
    #23;
    $display("[TB] reset state");
    checkOutput("rst_cmd_en", {31'd0, cmd_en}, 32'd0);
    checkOutput("rst_last_grant", {31'd0, last_grant}, 32'd1);
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_acks", {30'd0, rd_ack, wr_ack}, 32'd0);

    $display("[TB] uncalibrated with read pending");
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 30'h103, 6'd63, 1'b0, 30'd0, 6'd0);
    countCycles(100, ens, acks, rdys);
    checkOutput("nocal_cmd_en", ens, 0);
    checkOutput("nocal_acks", acks, 0);
    checkOutput("nocal_ready", rdys, 0);

    $display("[TB] first read after calibration");
    mem_calib_done = 1'b1;
    waitCmd(10, n);
    checkOutput("rd1_cmd_en", {31'd0, cmd_en}, 32'd1);
    checkOutput("rd1_instr", {29'd0, cmd_instr}, 32'd1);
    checkOutput("rd1_addr", {2'd0, cmd_byte_addr}, 32'h100);
    checkOutput("rd1_bl", {26'd0, cmd_bl}, 32'd63);
    checkOutput("rd1_acks", {30'd0, rd_ack, wr_ack}, 32'b10);
    checkOutput("rd1_last_grant", {31'd0, last_grant}, 32'd0);
    rd_req = 1'b0;
    tick();
    checkOutput("rd1_pulse_end", {30'd0, cmd_en, rd_ack}, 32'd0);
    checkOutput("rd1_instr_hold", {29'd0, cmd_instr}, 32'd1);

    $display("[TB] write gated on write FIFO fill");
    applyStimulus(1'b0, 30'h40, 6'd7, 1'b1, 30'h2007, 6'd15);
    wr_count = 7'd15;
    countCycles(20, ens, acks, rdys);
    checkOutput("wrgate_cmd_en", ens, 0);
    checkOutput("wrgate_ready", {31'd0, ready}, 32'd1);
    wr_count = 7'd16;
    tick();
    checkOutput("wr1_cmd_en", {31'd0, cmd_en}, 32'd1);
    checkOutput("wr1_instr", {29'd0, cmd_instr}, 32'd0);
    checkOutput("wr1_addr", {2'd0, cmd_byte_addr}, 32'h2004);
    checkOutput("wr1_bl", {26'd0, cmd_bl}, 32'd15);
    checkOutput("wr1_acks", {30'd0, rd_ack, wr_ack}, 32'b01);
    checkOutput("wr1_last_grant", {31'd0, last_grant}, 32'd1);

    $display("[TB] round-robin alternation");
    applyStimulus(1'b1, 30'h40, 6'd7, 1'b1, 30'h80, 6'd7);
    wr_count = 7'd64;
    for (int k = 0; k < 4; k++) begin
      waitCmd(10, n);
      expInstr = (k % 2 == 0) ? 3'b001 : 3'b000;
      checkOutput($sformatf("rr%0d_instr", k), {29'd0, cmd_instr}, {29'd0, expInstr});
      checkOutput($sformatf("rr%0d_addr", k), {2'd0, cmd_byte_addr}, (k % 2 == 0) ? 32'h40 : 32'h80);
      checkOutput($sformatf("rr%0d_acks", k), {30'd0, rd_ack, wr_ack}, (k % 2 == 0) ? 32'b10 : 32'b01);
      checkOutput($sformatf("rr%0d_spacing", k), n, 3);
    end

    $display("[TB] command FIFO full blocks grants");
    cmd_full = 1'b1;
    countCycles(20, ens, acks, rdys);
    checkOutput("full_cmd_en", ens, 0);
    checkOutput("full_acks", acks, 0);
    cmd_full = 1'b0;
    waitCmd(10, n);
    checkOutput("afterfull_latency", n, 1);
    checkOutput("afterfull_instr", {29'd0, cmd_instr}, 32'd1);
    checkOutput("afterfull_acks", {30'd0, rd_ack, wr_ack}, 32'b10);

    $display("[TB] calibration lost after issue");
    mem_calib_done = 1'b0;
    countCycles(30, ens, acks, rdys);
    checkOutput("callost_cmd_en", ens, 0);
    checkOutput("callost_acks", acks, 0);
    checkOutput("callost_ready", {31'd0, ready}, 32'd0);
    mem_calib_done = 1'b1;
    waitCmd(10, n);
    checkOutput("recal_latency", n, 4);
    checkOutput("recal_instr", {29'd0, cmd_instr}, 32'd0);
    checkOutput("recal_acks", {30'd0, rd_ack, wr_ack}, 32'b01);
    checkOutput("recal_addr", {2'd0, cmd_byte_addr}, 32'h80);

    $display("[TB] reset during issue");
    reset = 1'b0;
    #1;
    checkOutput("rstiss_strobes", {29'd0, cmd_en, rd_ack, wr_ack}, 32'd0);
    checkOutput("rstiss_fields", {3'd0, cmd_instr, cmd_bl, cmd_byte_addr[19:0]}, 32'd0);
    checkOutput("rstiss_last_grant", {31'd0, last_grant}, 32'd1);
    checkOutput("rstiss_ready", {31'd0, ready}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    waitCmd(10, n);
    checkOutput("postrst_latency", n, 4);
    checkOutput("postrst_instr", {29'd0, cmd_instr}, 32'd1);
    checkOutput("postrst_acks", {30'd0, rd_ack, wr_ack}, 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
